regfile_writeback_queue: RTL and testbench
==========================================

// Module: regfile_writeback_queue
// PURPOSE
//  Producer side of the register-file write port (WE3/A3/WD3). Accepts write requests from the
//  ALU path and the load path via valid/ready, buffers them in a small FIFO, and drains one write
//  per cycle into the register file. Provides per-read-port pending-write flags so decode can stall
//  on RAW hazards against queued writes. Sits between execute/memory stages and register_file.
// PARAMETERS
//  DEPTH  4   FIFO entries; power of 2, >= 2
//  AW     5   register address width (32 registers)
//  DW     32  register data width
// PORTS
//  clk        in   1    single clock; all state updates on posedge clk
//  rst        in   1    synchronous, active-high reset
//  alu_valid  in   1    ALU write request valid
//  alu_addr   in   AW   ALU destination register
//  alu_data   in   DW   ALU result
//  alu_ready  out  1    ALU request accepted this cycle when alu_valid & alu_ready
//  ld_valid   in   1    load write request valid
//  ld_addr    in   AW   load destination register
//  ld_data    in   DW   load data
//  ld_ready   out  1    load request accepted when ld_valid & ld_ready
//  wr_stall   in   1    register-file port unavailable; hold head entry
//  we3        out  1    register-file write enable
//  a3         out  AW   register-file write address
//  wd3        out  DW   register-file write data
//  q1_addr    in   AW   read-port-1 address (A1) to check
//  q2_addr    in   AW   read-port-2 address (A2) to check
//  q1_pend    out  1    a queued write targets q1_addr
//  q2_pend    out  1    a queued write targets q2_addr
//  q1_fwd     out  DW   bypass data for q1 (see CONFIGURATION)
//  q2_fwd     out  DW   bypass data for q2
//  count      out  $clog2(DEPTH)+1  entries currently queued
// BEHAVIOUR
//  - Reset: FIFO empty, rd/wr pointers 0, count=0, we3=0, a3=0, wd3=0; queued writes discarded.
//  - Arbitration: at most one enqueue per cycle; ALU has fixed priority.
//    alu_ready = !full; ld_ready = !full & !alu_valid. ready never depends on same-cycle dequeue.
//  - Writes to x0 (addr==0) are accepted (handshake completes) but not enqueued.
//  - we3 = !empty & !wr_stall; a3/wd3 = head entry (combinational from registered FIFO), 0 when empty.
//    Dequeue on posedge when we3=1. Latency: request accepted in cycle N -> we3 earliest in N+1.
//  - Simultaneous enqueue+dequeue: count unchanged, both pointers advance. Full+dequeue: no enqueue.
//  - Pointers wrap modulo DEPTH; count distinguishes full (count==DEPTH) from empty (count==0).
//  - Order preserved: register file sees writes in acceptance order.
//  - qN_pend = 1 iff qN_addr!=0 and any valid entry (including head) has addr==qN_addr; combinational.
// CONFIGURATION
//  WB_BYPASS_EN defined: qN_fwd = data of youngest valid entry matching qN_addr (0 if none);
//    decode may use it instead of stalling.
//  WB_BYPASS_EN undefined: qN_fwd tied to 0; no match-priority logic synthesized; qN_pend unchanged.
// STRUCTURE
//  - Shared package/header: REG_AW, REG_DW localparams; write-entry layout {addr[AW-1:0], data[DW-1:0]}.
//  - One sub-module: wb_fifo (DEPTH x entry storage, pointers, count, full/empty).
//    Top holds arbitration, x0 filter, hazard/bypass compare.
// TESTING
//  1 ALU write x5=0xDEAD_BEEF, empty FIFO -> next cycle we3=1,a3=5,wd3=0xDEADBEEF; count 1 -> 0.
//  2 alu_valid & ld_valid same cycle -> ALU accepted, ld_ready=0; load written one cycle after ALU.
//  3 wr_stall=1, enqueue 4 writes -> count=4, alu_ready=0; release -> 4 writes in order, 1/cycle.
//  4 ALU write to x0 -> alu_ready=1, count stays 0, we3 never asserts.
//  5 queue x7=1 then x7=2, stalled; q1_addr=7 -> q1_pend=1; with WB_BYPASS_EN q1_fwd=2, else 0.
//  6 rst asserted with 3 entries queued -> next cycle count=0, we3=0, q1_pend=0.

Source files
------------

// File: rtl/regfile_writeback_queue_pkg.sv
// regfile_writeback_queue_pkg: shared widths, queue depth and write-entry layout
package regfile_writeback_queue_pkg;
    localparam int REG_AW   = 5;
    localparam int REG_DW   = 32;
    localparam int WB_DEPTH = 4;
    localparam int WB_PW    = $clog2(WB_DEPTH);
    localparam int WB_CW    = WB_PW + 1;
    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_DW-1:0] reg_data_t;
    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_queue_if.sv
// regfile_writeback_queue_if: request, register-file write and hazard-query signals of the writeback queue
interface regfile_writeback_queue_if;
    import regfile_writeback_queue_pkg::*;
    logic             alu_valid;
    reg_addr_t        alu_addr;
    reg_data_t        alu_data;
    logic             alu_ready;
    logic             ld_valid;
    reg_addr_t        ld_addr;
    reg_data_t        ld_data;
    logic             ld_ready;
    logic             wr_stall;
    logic             we3;
    reg_addr_t        a3;
    reg_data_t        wd3;
    reg_addr_t        q1_addr;
    reg_addr_t        q2_addr;
    logic             q1_pend;
    logic             q2_pend;
    reg_data_t        q1_fwd;
    reg_data_t        q2_fwd;
    logic [WB_CW-1:0] count;
    modport slave (
        input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data, wr_stall, q1_addr, q2_addr,
        output alu_ready, ld_ready, we3, a3, wd3, q1_pend, q2_pend, q1_fwd, q2_fwd, count
    );
    modport master (
        output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data, wr_stall, q1_addr, q2_addr,
        input  alu_ready, ld_ready, we3, a3, wd3, q1_pend, q2_pend, q1_fwd, q2_fwd, count
    );
endinterface

// File: rtl/regfile_writeback_queue_wb_fifo.sv
// wb_fifo: circular buffer of pending register writes with occupancy count; exposes all slots for hazard checks
module wb_fifo
    import regfile_writeback_queue_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  wb_entry_t        entry_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WB_CW-1:0] count_o,
    output logic [WB_PW-1:0] rd_ptr_o,
    output wb_entry_t        mem_o [WB_DEPTH]
);
    logic [WB_PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WB_CW-1:0] count_q, count_d;
    wb_entry_t        mem_q [WB_DEPTH];
    logic             do_push, do_pop;

    assign full_o   = count_q == WB_CW'(WB_DEPTH);
    assign empty_o  = count_q == '0;
    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;
    assign count_o  = count_q;
    assign rd_ptr_o = rd_ptr_q;
    assign mem_o    = mem_q;

    // pointers wrap naturally at the power-of-two depth; count separates full from empty
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + WB_PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + WB_PW'(1) : rd_ptr_q;
        count_d  = count_q + WB_CW'(do_push) - WB_CW'(do_pop);
    end

    // pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // entry storage needs no reset: slots are only read while counted as valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= entry_i;
    end
endmodule

// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: arbitrates ALU/load writes into a FIFO draining to the register-file write port,
// with RAW pending flags per read port; define WB_BYPASS_EN to also return youngest matching queued data
module regfile_writeback_queue
    import regfile_writeback_queue_pkg::*;
(
    input logic                      clk,
    input logic                      rst,
    regfile_writeback_queue_if.slave wb
);
    logic             full, empty, alu_fire, ld_fire, push;
    logic [WB_PW-1:0] rd_ptr;
    wb_entry_t        entry, head;
    wb_entry_t        mem [WB_DEPTH];

    assign wb.alu_ready = !full;
    assign wb.ld_ready  = !full && !wb.alu_valid;
    assign alu_fire     = wb.alu_valid && wb.alu_ready;
    assign ld_fire      = wb.ld_valid && wb.ld_ready;

    // select the accepted request; x0 writes complete the handshake but are dropped
    always_comb begin
        entry.addr = alu_fire ? wb.alu_addr : wb.ld_addr;
        entry.data = alu_fire ? wb.alu_data : wb.ld_data;
        push       = (alu_fire || ld_fire) && entry.addr != '0;
    end

    wb_fifo u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (push),
        .entry_i  (entry),
        .pop_i    (wb.we3),
        .full_o   (full),
        .empty_o  (empty),
        .count_o  (wb.count),
        .rd_ptr_o (rd_ptr),
        .mem_o    (mem)
    );

    assign head   = mem[rd_ptr];
    assign wb.we3 = !empty && !wb.wr_stall;
    assign wb.a3  = empty ? '0 : head.addr;
    assign wb.wd3 = empty ? '0 : head.data;

    // flag any live entry targeting a read-port address; x0 is never a hazard
    always_comb begin
        wb.q1_pend = 1'b0;
        wb.q2_pend = 1'b0;
        for (int a = 0; a < WB_DEPTH; a++) begin
            if (WB_CW'(a) < wb.count) begin
                wb.q1_pend = wb.q1_pend | (wb.q1_addr != '0 && mem[rd_ptr + WB_PW'(a)].addr == wb.q1_addr);
                wb.q2_pend = wb.q2_pend | (wb.q2_addr != '0 && mem[rd_ptr + WB_PW'(a)].addr == wb.q2_addr);
            end
        end
    end

`ifdef WB_BYPASS_EN
    // walk oldest to youngest so the youngest matching entry wins
    always_comb begin
        wb.q1_fwd = '0;
        wb.q2_fwd = '0;
        for (int a = 0; a < WB_DEPTH; a++) begin
            if (WB_CW'(a) < wb.count && wb.q1_addr != '0 && mem[rd_ptr + WB_PW'(a)].addr == wb.q1_addr)
                wb.q1_fwd = mem[rd_ptr + WB_PW'(a)].data;
            if (WB_CW'(a) < wb.count && wb.q2_addr != '0 && mem[rd_ptr + WB_PW'(a)].addr == wb.q2_addr)
                wb.q2_fwd = mem[rd_ptr + WB_PW'(a)].data;
        end
    end
`else
    assign wb.q1_fwd = '0;
    assign wb.q2_fwd = '0;
`endif
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb_regfile_writeback_queue: directed checks of arbitration, ordering, stall, x0 filter, hazards and reset
module tb_regfile_writeback_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_writeback_queue_if wb();

    regfile_writeback_queue dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_alu(input logic [4:0] addr, input logic [31:0] data);
        wb.alu_valid = 1'b1;
        wb.alu_addr  = addr;
        wb.alu_data  = data;
        step();
        wb.alu_valid = 1'b0;
    endtask

    initial begin
        wb.alu_valid = 1'b0; wb.alu_addr = '0; wb.alu_data = '0;
        wb.ld_valid  = 1'b0; wb.ld_addr  = '0; wb.ld_data  = '0;
        wb.wr_stall  = 1'b0; wb.q1_addr  = '0; wb.q2_addr  = '0;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_count", 64'(wb.count), 0);
        chk("rst_we3", 64'(wb.we3), 0);
        chk("rst_a3", 64'(wb.a3), 0);
        chk("rst_wd3", 64'(wb.wd3), 0);
        chk("rst_alu_ready", 64'(wb.alu_ready), 1);
        chk("rst_ld_ready", 64'(wb.ld_ready), 1);
        step();

        // single ALU write reaches the port the next cycle
        wb.alu_valid = 1'b1; wb.alu_addr = 5'd5; wb.alu_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t1_ready", 64'(wb.alu_ready), 1);
        chk("t1_we3_same_cycle", 64'(wb.we3), 0);
        step();
        wb.alu_valid = 1'b0;
        @(negedge clk);
        chk("t1_we3", 64'(wb.we3), 1);
        chk("t1_a3", 64'(wb.a3), 5);
        chk("t1_wd3", 64'(wb.wd3), 64'h0DEAD_BEEF);
        chk("t1_count1", 64'(wb.count), 1);
        step();
        @(negedge clk);
        chk("t1_count0", 64'(wb.count), 0);
        chk("t1_we3_idle", 64'(wb.we3), 0);
        step();

        // ALU wins over load; load follows one cycle later
        wb.alu_valid = 1'b1; wb.alu_addr = 5'd3; wb.alu_data = 32'h11;
        wb.ld_valid  = 1'b1; wb.ld_addr  = 5'd4; wb.ld_data  = 32'h22;
        @(negedge clk);
        chk("t2_alu_ready", 64'(wb.alu_ready), 1);
        chk("t2_ld_ready", 64'(wb.ld_ready), 0);
        step();
        wb.alu_valid = 1'b0;
        @(negedge clk);
        chk("t2_ld_ready2", 64'(wb.ld_ready), 1);
        chk("t2_a3_alu", 64'(wb.a3), 3);
        chk("t2_wd3_alu", 64'(wb.wd3), 64'h11);
        step();
        wb.ld_valid = 1'b0;
        @(negedge clk);
        chk("t2_we3_ld", 64'(wb.we3), 1);
        chk("t2_a3_ld", 64'(wb.a3), 4);
        chk("t2_wd3_ld", 64'(wb.wd3), 64'h22);
        chk("t2_count", 64'(wb.count), 1);
        step();

        // fill under stall, attempt a push while full, then drain in order
        wb.wr_stall = 1'b1;
        for (int i = 0; i < 4; i++) push_alu(5'(10 + i), 32'h100 + 32'(i));
        wb.alu_valid = 1'b1; wb.alu_addr = 5'd20; wb.alu_data = 32'h999;
        @(negedge clk);
        chk("t3_count_full", 64'(wb.count), 4);
        chk("t3_alu_ready", 64'(wb.alu_ready), 0);
        chk("t3_ld_ready", 64'(wb.ld_ready), 0);
        chk("t3_we3_stall", 64'(wb.we3), 0);
        step();
        wb.alu_valid = 1'b0;
        wb.wr_stall  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("t3_we3_%0d", i), 64'(wb.we3), 1);
            chk($sformatf("t3_a3_%0d", i), 64'(wb.a3), 64'(10 + i));
            chk($sformatf("t3_wd3_%0d", i), 64'(wb.wd3), 64'(32'h100 + 32'(i)));
            step();
        end
        @(negedge clk);
        chk("t3_drained", 64'(wb.count), 0);
        chk("t3_we3_end", 64'(wb.we3), 0);
        step();

        // x0 write handshakes but never enqueues
        wb.alu_valid = 1'b1; wb.alu_addr = 5'd0; wb.alu_data = 32'h55;
        @(negedge clk);
        chk("t4_ready", 64'(wb.alu_ready), 1);
        step();
        wb.alu_valid = 1'b0;
        @(negedge clk);
        chk("t4_count", 64'(wb.count), 0);
        chk("t4_we3", 64'(wb.we3), 0);
        step();

        // hazard flags and youngest-match bypass
        wb.wr_stall = 1'b1;
        push_alu(5'd7, 32'h1);
        push_alu(5'd7, 32'h2);
        push_alu(5'd9, 32'h3);
        wb.q1_addr = 5'd7; wb.q2_addr = 5'd9;
        @(negedge clk);
        chk("t5_count", 64'(wb.count), 3);
        chk("t5_q1_pend", 64'(wb.q1_pend), 1);
        chk("t5_q1_fwd", 64'(wb.q1_fwd), BYP ? 64'h2 : 64'h0);
        chk("t5_q2_pend", 64'(wb.q2_pend), 1);
        chk("t5_q2_fwd", 64'(wb.q2_fwd), BYP ? 64'h3 : 64'h0);
        wb.q2_addr = 5'd8;
        wb.q1_addr = 5'd0;
        @(negedge clk);
        chk("t5_q2_miss", 64'(wb.q2_pend), 0);
        chk("t5_q2_fwd_miss", 64'(wb.q2_fwd), 0);
        chk("t5_q1_x0", 64'(wb.q1_pend), 0);
        step();

        // reset discards queued writes
        wb.q1_addr = 5'd7;
        rst = 1'b1;
        step();
        rst = 1'b0;
        wb.wr_stall = 1'b0;
        @(negedge clk);
        chk("t6_count", 64'(wb.count), 0);
        chk("t6_we3", 64'(wb.we3), 0);
        chk("t6_q1_pend", 64'(wb.q1_pend), 0);
        chk("t6_a3", 64'(wb.a3), 0);
        chk("t6_wd3", 64'(wb.wd3), 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
